// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (req0) and load (req1) write-back.
// Optional WB_FWD_EN adds two read-bypass ports that forward the registered write data.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wr,
  output logic [XLEN-1:0] rf_wd,
  output logic [NREG-1:0] busy
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]   rr1,
  input  logic [AW-1:0]   rr2,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  output logic [XLEN-1:0] rd1_out,
  output logic [XLEN-1:0] rd2_out
`endif
);

  typedef enum logic {
    PRI_ALU  = 1'b0,
    PRI_LOAD = 1'b1
  } rr_t;

  rr_t             rr_ptr;
  logic            grant0;
  logic            grant1;
  logic            xfer;
  logic            contested;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_next;

  // Grants are suppressed during reset so a waiting requester simply re-presents afterwards.
  always_comb begin
    contested = req0_valid && req1_valid;
    grant0    = rst_n && req0_valid && (!req1_valid || (rr_ptr == PRI_ALU));
    grant1    = rst_n && req1_valid && (!req0_valid || (rr_ptr == PRI_LOAD));
    xfer      = grant0 || grant1;
    sel_rd    = grant1 ? req1_rd : req0_rd;
    sel_data  = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Clear applied before set so a fresh allocation outranks the retiring producer.
  always_comb begin
    busy_next = busy;
    if (xfer && (sel_rd != '0)) begin
      busy_next[sel_rd] = 1'b0;
    end
    if (alloc_valid && (alloc_rd != '0)) begin
      busy_next[alloc_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we  <= 1'b0;
      rf_wr  <= '0;
      rf_wd  <= '0;
      busy   <= '0;
      rr_ptr <= PRI_ALU;
    end else begin
      rf_we <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_wr <= sel_rd;
        rf_wd <= sel_data;
      end
      if (contested) begin
        rr_ptr <= (rr_ptr == PRI_ALU) ? PRI_LOAD : PRI_ALU;
      end
      busy <= busy_next;
    end
  end

`ifdef WB_FWD_EN
  always_comb begin
    rd1_out = (rf_we && (rf_wr == rr1) && (rr1 != '0)) ? rf_wd : rd1_in;
    rd2_out = (rf_we && (rf_wr == rr2) && (rr2 != '0)) ? rf_wd : rd2_in;
  end
`endif

endmodule
